// File: rtl/can_ifd_pkg.sv
// Shared types and default configuration for the CAN interframe tracker.
package can_ifd_pkg;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_S1    = 2'd1,
      S_S2    = 2'd2,
      S_VALID = 2'd3
   } sample_t;

   typedef enum logic [1:0] {
      P_FRAME        = 2'd0,
      P_INTERMISSION = 2'd1,
      P_SUSPEND      = 2'd2,
      P_IDLE         = 2'd3
   } phase_t;

   localparam int unsigned DEF_RECESSIVE_THRESH  = 10;
   localparam int unsigned DEF_INTERMISSION_BITS = 3;
   localparam int unsigned DEF_SUSPEND_BITS      = 8;
   localparam int unsigned DEF_CNT_W             = 4;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/can_bit_voter.sv
// Resolves one CAN bit from one or three sample strobes (majority of three).
module can_bit_voter
   import can_ifd_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    i_din,
   input  logic    i_sample_pulse,
   input  logic    i_rate_sel,
   output logic    o_bit_valid,
   output logic    o_bit_value,
   output sample_t o_state
);

   sample_t r_state;
   logic    r_s0;
   logic    r_s1;
   logic    r_value;

   // The rate choice is folded into the S_INIT transition, so a mid-bit change
   // of i_rate_sel cannot alter the bit already in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
         r_s0    <= 1'b0;
         r_s1    <= 1'b0;
         r_value <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (i_sample_pulse) begin
                  r_s0 <= i_din;
                  if (i_rate_sel) begin
                     r_state <= S_S1;
                  end else begin
                     r_value <= i_din;
                     r_state <= S_VALID;
                  end
               end
            end
            S_S1: begin
               if (i_sample_pulse) begin
                  r_s1    <= i_din;
                  r_state <= S_S2;
               end
            end
            S_S2: begin
               if (i_sample_pulse) begin
                  r_value <= maj3(r_s0, r_s1, i_din);
                  r_state <= S_VALID;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign o_bit_valid = (r_state == S_VALID);
   assign o_bit_value = r_value;
   assign o_state     = r_state;

endmodule

// File: rtl/can_interframe_tracker.sv
// CAN bus phase tracker: frame -> intermission -> (suspend) -> idle, with
// overload/SOF pulses. Define IFD_SUSPEND_TX_EN to enable the suspend phase.
module can_interframe_tracker
   import can_ifd_pkg::*;
#(
   parameter int unsigned RECESSIVE_THRESH  = DEF_RECESSIVE_THRESH,
   parameter int unsigned INTERMISSION_BITS = DEF_INTERMISSION_BITS,
   parameter int unsigned SUSPEND_BITS      = DEF_SUSPEND_BITS,
   parameter int unsigned CNT_W             = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dIn,
   input  logic             samplePulse,
   input  logic             rateSelector,
   input  logic             errorPassive,
   output logic             bitValid,
   output logic             bitValue,
   output logic             interframePeriod,
   output logic             intermission,
   output logic             busIdle,
   output logic             overloadDetect,
   output logic             sofDetect,
   output logic             suspendActive,
   output logic [CNT_W-1:0] bitCount,
   output logic [7:0]       DBG
);

   localparam logic [CNT_W:0] L_THRESH = (CNT_W+1)'(RECESSIVE_THRESH);
   localparam logic [CNT_W:0] L_INTER  = (CNT_W+1)'(INTERMISSION_BITS);
   localparam logic [CNT_W:0] L_SUSP   = (CNT_W+1)'(SUSPEND_BITS);

   logic             w_bit_valid;
   logic             w_bit_value;
   sample_t          w_state;
   phase_t           r_phase;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovl;
   logic             r_sof;
   logic [CNT_W:0]   w_inc;
   logic [CNT_W+3:0] w_dbg_full;

   can_bit_voter u_voter (
      .clk            (clk),
      .reset          (reset),
      .i_din          (dIn),
      .i_sample_pulse (samplePulse),
      .i_rate_sel     (rateSelector),
      .o_bit_valid    (w_bit_valid),
      .o_bit_value    (w_bit_value),
      .o_state        (w_state)
   );

   // One bit wider than the counter so threshold compares never see a wrap.
   assign w_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= P_FRAME;
         r_cnt   <= '0;
         r_ovl   <= 1'b0;
         r_sof   <= 1'b0;
      end else begin
         r_ovl <= 1'b0;
         r_sof <= 1'b0;
         if (w_bit_valid) begin
            case (r_phase)
               P_FRAME: begin
                  if (!w_bit_value) begin
                     r_cnt <= '0;
                  end else if (w_inc >= L_THRESH) begin
                     r_phase <= P_INTERMISSION;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_inc[CNT_W-1:0];
                  end
               end
               P_INTERMISSION: begin
                  if (!w_bit_value) begin
                     // Only the final intermission bit may legally carry a SOF.
                     if (w_inc < L_INTER) r_ovl <= 1'b1;
                     else                 r_sof <= 1'b1;
                     r_phase <= P_FRAME;
                     r_cnt   <= '0;
                  end else if (w_inc >= L_INTER) begin
`ifdef IFD_SUSPEND_TX_EN
                     r_phase <= errorPassive ? P_SUSPEND : P_IDLE;
`else
                     r_phase <= P_IDLE;
`endif
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_inc[CNT_W-1:0];
                  end
               end
`ifdef IFD_SUSPEND_TX_EN
               P_SUSPEND: begin
                  if (!w_bit_value) begin
                     r_sof   <= 1'b1;
                     r_phase <= P_FRAME;
                     r_cnt   <= '0;
                  end else if (w_inc >= L_SUSP) begin
                     r_phase <= P_IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_inc[CNT_W-1:0];
                  end
               end
`endif
               P_IDLE: begin
                  if (!w_bit_value) begin
                     r_sof   <= 1'b1;
                     r_phase <= P_FRAME;
                     r_cnt   <= '0;
                  end else if (r_cnt != '1) begin
                     r_cnt <= w_inc[CNT_W-1:0];
                  end
               end
               default: begin
                  r_phase <= P_FRAME;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

`ifdef IFD_SUSPEND_TX_EN
   assign suspendActive = (r_phase == P_SUSPEND);
`else
   logic w_unused_cfg;
   assign w_unused_cfg  = ^{errorPassive, L_SUSP};
   assign suspendActive = 1'b0;
`endif

   assign bitValid         = w_bit_valid;
   assign bitValue         = w_bit_value;
   assign interframePeriod = (r_phase != P_FRAME);
   assign intermission     = (r_phase == P_INTERMISSION);
   assign busIdle          = (r_phase == P_IDLE);
   assign overloadDetect   = r_ovl;
   assign sofDetect        = r_sof;
   assign bitCount         = r_cnt;
   assign w_dbg_full       = {w_state, r_phase, r_cnt};
   assign DBG              = 8'(w_dbg_full);

endmodule

// File: tb/tb_can_interframe_tracker.sv
// Directed bench for can_interframe_tracker with a bit-level reference model.
module tb_can_interframe_tracker;

   localparam int THRESH = 10;
   localparam int INTER  = 3;
   localparam int SUSP   = 8;
   localparam int CW     = 4;
   localparam int PF = 0, PI = 1, PS = 2, PD = 3;
`ifdef IFD_SUSPEND_TX_EN
   localparam bit SUSP_EN = 1'b1;
`else
   localparam bit SUSP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, dIn, samplePulse, rateSelector, errorPassive;
   logic bitValid, bitValue, interframePeriod, intermission, busIdle;
   logic overloadDetect, sofDetect, suspendActive;
   logic [CW-1:0] bitCount;
   logic [7:0]    DBG;

   always #5 clk = ~clk;

   can_interframe_tracker #(
      .RECESSIVE_THRESH  (THRESH),
      .INTERMISSION_BITS (INTER),
      .SUSPEND_BITS      (SUSP),
      .CNT_W             (CW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .dIn              (dIn),
      .samplePulse      (samplePulse),
      .rateSelector     (rateSelector),
      .errorPassive     (errorPassive),
      .bitValid         (bitValid),
      .bitValue         (bitValue),
      .interframePeriod (interframePeriod),
      .intermission     (intermission),
      .busIdle          (busIdle),
      .overloadDetect   (overloadDetect),
      .sofDetect        (sofDetect),
      .suspendActive    (suspendActive),
      .bitCount         (bitCount),
      .DBG              (DBG)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: bus phase, counter, expected pulses and sampler progress.
   int   m_phase = PF;
   int   m_cnt   = 0;
   int   exp_samp = 0;
   logic exp_valid = 1'b0;
   logic exp_bv = 1'b0;
   logic exp_ovl = 1'b0;
   logic exp_sof = 1'b0;
   bit   check_en = 1'b0;
   bit   inject = 1'b0;
   logic seen_bv, seen_ovl, seen_sof;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_bit(input logic b);
      if (m_phase == PF) begin
         if (b) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == THRESH) begin m_phase = PI; m_cnt = 0; end
         end else m_cnt = 0;
      end else if (m_phase == PI) begin
         if (!b) begin
            if (m_cnt == INTER - 1) exp_sof = 1'b1; else exp_ovl = 1'b1;
            m_phase = PF; m_cnt = 0;
         end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == INTER) begin
               m_phase = (SUSP_EN && errorPassive) ? PS : PD;
               m_cnt = 0;
            end
         end
      end else if (m_phase == PS) begin
         if (!b) begin exp_sof = 1'b1; m_phase = PF; m_cnt = 0; end
         else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == SUSP) begin m_phase = PD; m_cnt = 0; end
         end
      end else begin
         if (!b) begin exp_sof = 1'b1; m_phase = PF; m_cnt = 0; end
         else if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("bitValid", bitValid, exp_valid);
         if (exp_valid) chk("bitValue", bitValue, exp_bv);
         chk("interframePeriod", interframePeriod, m_phase != PF);
         chk("intermission", intermission, m_phase == PI);
         chk("busIdle", busIdle, m_phase == PD);
         chk("suspendActive", suspendActive, m_phase == PS);
         chk("overloadDetect", overloadDetect, exp_ovl);
         chk("sofDetect", sofDetect, exp_sof);
         chk("bitCount", bitCount, m_cnt);
         chk("DBG", DBG, exp_samp * 64 + m_phase * 16 + m_cnt);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic capture(input logic v);
      @(posedge clk); #1;
      dIn = v; samplePulse = 1'b1;
      @(posedge clk); #1;
      samplePulse = 1'b0; dIn = 1'b1;
   endtask

   task automatic send_bit(input logic rate, input logic a, input logic b, input logic c);
      logic v;
      rateSelector = rate;
      if (rate) begin
         capture(a); exp_samp = 1;
         rateSelector = 1'b0;  // must not affect the bit in progress
         cyc();
         capture(b); exp_samp = 2;
         cyc();
         capture(c);
         v = ((int'(a) + int'(b) + int'(c)) >= 2);
      end else begin
         capture(a);
         v = a;
      end
      exp_samp = 3; exp_valid = 1'b1; exp_bv = v;
      seen_bv = bitValue;
      if (inject) begin samplePulse = 1'b1; dIn = 1'b0; end
      @(posedge clk); #1;
      samplePulse = 1'b0; dIn = 1'b1;
      exp_samp = 0; exp_valid = 1'b0;
      model_bit(v);
      seen_ovl = overloadDetect; seen_sof = sofDetect;
      cyc();
      exp_ovl = 1'b0; exp_sof = 1'b0;
   endtask

   task automatic send_n(input int n, input logic v);
      for (int i = 0; i < n; i++) send_bit(1'b0, v, v, v);
   endtask

   task automatic clear_model();
      m_phase = PF; m_cnt = 0; exp_samp = 0;
      exp_valid = 1'b0; exp_ovl = 1'b0; exp_sof = 1'b0;
   endtask

   initial begin
      reset = 1'b1; dIn = 1'b1; samplePulse = 1'b0;
      rateSelector = 1'b0; errorPassive = 1'b0;
      #3;
      check_en = 1'b1;
      chk("rst_ifp", interframePeriod, 0);
      chk("rst_dbg", DBG, 0);
      chk("rst_valid", bitValid, 0);
      cyc(); cyc();
      reset = 1'b0;
      cyc();

      // Majority vote, with an ignored strobe during the valid cycle.
      send_bit(1'b1, 1'b1, 1'b0, 1'b1);
      chk("maj_101", seen_bv, 1);
      inject = 1'b1;
      send_bit(1'b1, 1'b0, 1'b0, 1'b1);
      inject = 1'b0;
      chk("maj_001", seen_bv, 0);

      // End of frame into intermission, then idle.
      send_n(10, 1'b1);
      chk("eof_ifp", interframePeriod, 1);
      chk("eof_intermission", intermission, 1);
      chk("eof_cnt", bitCount, 0);
      send_n(3, 1'b1);
      chk("idle_busIdle", busIdle, 1);
      chk("idle_cnt", bitCount, 0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_sof", seen_sof, 1);
      chk("idle_sof_ovl", seen_ovl, 0);
      chk("idle_drop", busIdle, 0);

      // Overload at intermission bit 1 and bit 0, SOF at bit 2.
      send_n(11, 1'b1);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovl1_ovl", seen_ovl, 1);
      chk("ovl1_sof", seen_sof, 0);
      chk("ovl1_ifp", interframePeriod, 0);
      send_n(10, 1'b1);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovl0_ovl", seen_ovl, 1);
      send_n(12, 1'b1);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sof2_sof", seen_sof, 1);
      chk("sof2_ovl", seen_ovl, 0);

      // Idle counter saturates at its maximum.
      send_n(13, 1'b1);
      send_n(20, 1'b1);
      chk("sat_cnt", bitCount, 15);
      chk("sat_idle", busIdle, 1);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-bit while in intermission.
      send_n(10, 1'b1);
      chk("prerst_ifp", interframePeriod, 1);
      rateSelector = 1'b1;
      capture(1'b1); exp_samp = 1;
      #2;
      reset = 1'b1;
      clear_model();
      #1;
      chk("arst_ifp", interframePeriod, 0);
      chk("arst_intermission", intermission, 0);
      chk("arst_dbg", DBG, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      rateSelector = 1'b0;
      cyc();

      // Bus integration needs an unbroken recessive run.
      send_n(9, 1'b1);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      send_n(9, 1'b1);
      chk("integ_ifp_lo", interframePeriod, 0);
      send_n(1, 1'b1);
      chk("integ_ifp_hi", interframePeriod, 1);
      chk("integ_intermission", intermission, 1);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef IFD_SUSPEND_TX_EN
      errorPassive = 1'b1;
      send_n(13, 1'b1);
      chk("susp_active", suspendActive, 1);
      chk("susp_ifp", interframePeriod, 1);
      send_n(7, 1'b1);
      chk("susp_cnt7", bitCount, 7);
      chk("susp_still", suspendActive, 1);
      send_n(1, 1'b1);
      chk("susp_idle", busIdle, 1);
      chk("susp_off", suspendActive, 0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      send_n(13, 1'b1);
      send_n(4, 1'b1);
      chk("susp_cnt4", bitCount, 4);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      chk("susp_sof", seen_sof, 1);
      chk("susp_frame", interframePeriod, 0);
`else
      errorPassive = 1'b1;
      send_n(13, 1'b1);
      chk("nosusp_idle", busIdle, 1);
      chk("nosusp_active", suspendActive, 0);
`endif

      cyc();
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
